// File: rtl/cache_controller_pkg.sv
// Shared types and constants for the cache sequencing controller.
// Address layout: tag [14:12], index [11:2], word offset [1:0].
package cache_controller_pkg;

  localparam int OFS_WIDTH   = 2;
  localparam int LINE_WORDS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COMPARE  = 3'd1,
    ST_MEM_READ = 3'd2,
    ST_FILL     = 3'd3,
    ST_RESPOND  = 3'd4
  } state_t;

endpackage

// File: rtl/cache_line_buffer.sv
// Four-word staging register for a block fetched from main memory.
// Loaded in one cycle; any word can be read back by offset.
module cache_line_buffer
  import cache_controller_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic [WORD_LENGTH-1:0] i_word0,
  input  logic [WORD_LENGTH-1:0] i_word1,
  input  logic [WORD_LENGTH-1:0] i_word2,
  input  logic [WORD_LENGTH-1:0] i_word3,
  input  logic [OFS_WIDTH-1:0]   i_offset,
  output logic [WORD_LENGTH-1:0] o_rd_data,
  output logic [WORD_LENGTH-1:0] o_word0,
  output logic [WORD_LENGTH-1:0] o_word1,
  output logic [WORD_LENGTH-1:0] o_word2,
  output logic [WORD_LENGTH-1:0] o_word3
);

  logic [WORD_LENGTH-1:0] r_buf [LINE_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) r_buf[i] <= '0;
    end else if (i_load) begin
      r_buf[0] <= i_word0;
      r_buf[1] <= i_word1;
      r_buf[2] <= i_word2;
      r_buf[3] <= i_word3;
    end
  end

  assign o_rd_data = r_buf[i_offset];
  assign o_word0   = r_buf[0];
  assign o_word1   = r_buf[1];
  assign o_word2   = r_buf[2];
  assign o_word3   = r_buf[3];

endmodule

// File: rtl/cache_controller.sv
// Load-path sequencer for a direct-mapped 4-word-block cache with hit/miss stats.
// States: IDLE wait req | COMPARE cache lookup | MEM_READ fetch block | FILL write line | RESPOND return word
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int ADDR_WIDTH  = 15,
  parameter int WORD_LENGTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  output logic                   cpu_ready,
  output logic [WORD_LENGTH-1:0] cpu_data,
  output logic                   cpu_busy,
  output logic [ADDR_WIDTH-1:0]  cache_address,
  output logic                   cache_write,
  output logic [WORD_LENGTH-1:0] cache_data_in1,
  output logic [WORD_LENGTH-1:0] cache_data_in2,
  output logic [WORD_LENGTH-1:0] cache_data_in3,
  output logic [WORD_LENGTH-1:0] cache_data_in4,
  input  logic                   cache_hit,
  input  logic [WORD_LENGTH-1:0] cache_out,
  output logic                   mem_read,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ready,
  input  logic [WORD_LENGTH-1:0] mem_word0,
  input  logic [WORD_LENGTH-1:0] mem_word1,
  input  logic [WORD_LENGTH-1:0] mem_word2,
  input  logic [WORD_LENGTH-1:0] mem_word3,
  output logic [CNT_WIDTH-1:0]   hit_count,
  output logic [CNT_WIDTH-1:0]   miss_count
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_cpu_ready;
  logic [WORD_LENGTH-1:0] r_cpu_data;
  logic [CNT_WIDTH-1:0]   r_hit_count;
  logic [CNT_WIDTH-1:0]   r_miss_count;
  logic                   w_buf_load;
  logic [WORD_LENGTH-1:0] w_buf_rd;
  logic [WORD_LENGTH-1:0] w_buf0, w_buf1, w_buf2, w_buf3;

  cache_line_buffer #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_line_buffer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_buf_load),
    .i_word0  (mem_word0),
    .i_word1  (mem_word1),
    .i_word2  (mem_word2),
    .i_word3  (mem_word3),
    .i_offset (r_addr[OFS_WIDTH-1:0]),
    .o_rd_data(w_buf_rd),
    .o_word0  (w_buf0),
    .o_word1  (w_buf1),
    .o_word2  (w_buf2),
    .o_word3  (w_buf3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // mem_read and cache_write decode straight from state so a reset kills them at once.
  always_comb begin
    w_next_state = r_state;
    w_buf_load   = 1'b0;
    mem_read     = 1'b0;
    cache_write  = 1'b0;
    case (r_state)
      ST_IDLE:     if (cpu_req) w_next_state = ST_COMPARE;
      ST_COMPARE:  w_next_state = cache_hit ? ST_IDLE : ST_MEM_READ;
      ST_MEM_READ: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          w_buf_load   = 1'b1;
          w_next_state = ST_FILL;
        end
      end
      ST_FILL: begin
        cache_write  = 1'b1;
        w_next_state = ST_RESPOND;
      end
      ST_RESPOND:  w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_cpu_ready  <= 1'b0;
      r_cpu_data   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      if (r_state == ST_IDLE && cpu_req) r_addr <= cpu_addr;
      if (r_state == ST_COMPARE) begin
        if (cache_hit) begin
          r_cpu_ready <= 1'b1;
          r_cpu_data  <= cache_out;
          r_hit_count <= r_hit_count + 1'b1;
        end else begin
          r_miss_count <= r_miss_count + 1'b1;
        end
      end
      if (r_state == ST_RESPOND) begin
        r_cpu_ready <= 1'b1;
        r_cpu_data  <= w_buf_rd;
      end
    end
  end

  assign cpu_ready     = r_cpu_ready;
  assign cpu_data      = r_cpu_data;
  assign cpu_busy      = (r_state != ST_IDLE);
  assign cache_address = r_addr;
  assign mem_addr      = {r_addr[ADDR_WIDTH-1:OFS_WIDTH], {OFS_WIDTH{1'b0}}};
  assign hit_count     = r_hit_count;
  assign miss_count    = r_miss_count;

  // Offset 00 sits in the low word of the cache line, which is dataIn4.
  assign cache_data_in1 = w_buf3;
  assign cache_data_in2 = w_buf2;
  assign cache_data_in3 = w_buf1;
  assign cache_data_in4 = w_buf0;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural direct-mapped cache and memory.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [14:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_data;
  logic        cpu_busy;
  logic [14:0] cache_address;
  logic        cache_write;
  logic [31:0] cache_data_in1, cache_data_in2, cache_data_in3, cache_data_in4;
  logic        cache_hit;
  logic [31:0] cache_out;
  logic        mem_read;
  logic [14:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_word0, mem_word1, mem_word2, mem_word3;
  logic [15:0] hit_count, miss_count;

  int n_cmp = 0;
  int n_mis = 0;
  int lat;

  cache_controller dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_data(cpu_data), .cpu_busy(cpu_busy),
    .cache_address(cache_address), .cache_write(cache_write),
    .cache_data_in1(cache_data_in1), .cache_data_in2(cache_data_in2),
    .cache_data_in3(cache_data_in3), .cache_data_in4(cache_data_in4),
    .cache_hit(cache_hit), .cache_out(cache_out),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_word0(mem_word0), .mem_word1(mem_word1),
    .mem_word2(mem_word2), .mem_word3(mem_word3),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial forever #5 clk = ~clk;

  // Behavioural direct-mapped cache: valid bits untouched by rst.
  logic [1023:0] m_valid = '0;
  logic [2:0]    m_tag  [1024];
  logic [31:0]   m_data [1024][4];
  logic [9:0]    c_idx;
  assign c_idx     = cache_address[11:2];
  assign cache_hit = m_valid[c_idx] && (m_tag[c_idx] == cache_address[14:12]);
  assign cache_out = m_data[c_idx][cache_address[1:0]];

  always @(posedge clk) begin
    if (cache_write) begin
      m_valid[c_idx]   <= 1'b1;
      m_tag[c_idx]     <= cache_address[14:12];
      m_data[c_idx][0] <= cache_data_in4;
      m_data[c_idx][1] <= cache_data_in3;
      m_data[c_idx][2] <= cache_data_in2;
      m_data[c_idx][3] <= cache_data_in1;
    end
  end

  // Monitors sampled on the falling edge.
  int          wr_cnt = 0;
  int          rd_cyc = 0;
  logic [31:0] last_in1, last_in2, last_in3, last_in4;
  logic [14:0] last_mem_addr;
  initial forever begin
    @(negedge clk);
    if (cache_write) begin
      wr_cnt++;
      last_in1 = cache_data_in1;
      last_in2 = cache_data_in2;
      last_in3 = cache_data_in3;
      last_in4 = cache_data_in4;
    end
    if (mem_read) begin
      rd_cyc++;
      last_mem_addr = mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise cpu_req and count rising edges until cpu_ready; -1 on timeout.
  task automatic do_req(input logic [14:0] addr, input bit scramble, output int edges);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    edges    = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (scramble && n == 2) cpu_addr = 15'h2AAA;
      if (cpu_ready) begin
        edges = n;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  // Answer a block read three cycles after mem_read is first seen.
  task automatic mem_respond(input logic [31:0] w0, w1, w2, w3);
    bit seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (mem_read) begin
        seen = 1;
        break;
      end
    end
    if (seen) begin
      repeat (3) begin @(posedge clk); #1; end
      mem_word0 = w0; mem_word1 = w1; mem_word2 = w2; mem_word3 = w3;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
  endtask

  int wr0, rd0;

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; mem_ready = 1'b0;
    mem_word0 = '0; mem_word1 = '0; mem_word2 = '0; mem_word3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_busy", cpu_busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_cache_write", cache_write, 0);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_cache_addr", cache_address, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss on word 5
    wr0 = wr_cnt; rd0 = rd_cyc;
    fork
      mem_respond(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      do_req(15'd5, 0, lat);
    join
    chk("cold_latency", lat, 8);
    chk("cold_data", cpu_data, 32'hA1);
    chk("cold_mem_addr", last_mem_addr, 15'd4);
    chk("cold_rd_cycles", rd_cyc - rd0, 4);
    chk("cold_writes", wr_cnt - wr0, 1);
    chk("cold_in1", last_in1, 32'hA3);
    chk("cold_in2", last_in2, 32'hA2);
    chk("cold_in3", last_in3, 32'hA1);
    chk("cold_in4", last_in4, 32'hA0);
    chk("cold_misses", miss_count, 1);
    chk("cold_hits", hit_count, 0);

    // Hit on the freshly filled line
    wr0 = wr_cnt; rd0 = rd_cyc;
    do_req(15'd6, 0, lat);
    chk("hit_latency", lat, 2);
    chk("hit_data", cpu_data, 32'hA2);
    chk("hit_rd_cycles", rd_cyc - rd0, 0);
    chk("hit_writes", wr_cnt - wr0, 0);
    chk("hit_hits", hit_count, 1);

    // Conflict miss: same index, tag 1
    fork
      mem_respond(32'hB0, 32'hB1, 32'hB2, 32'hB3);
      do_req(15'h1005, 0, lat);
    join
    chk("conf_latency", lat, 8);
    chk("conf_mem_addr", last_mem_addr, 15'h1004);
    chk("conf_data", cpu_data, 32'hB1);
    chk("conf_misses", miss_count, 2);
    fork
      mem_respond(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      do_req(15'd5, 0, lat);
    join
    chk("refetch_latency", lat, 8);
    chk("refetch_data", cpu_data, 32'hA1);
    chk("refetch_misses", miss_count, 3);

    // Address changes while busy are ignored
    fork
      mem_respond(32'hB0, 32'hB1, 32'hB2, 32'hB3);
      do_req(15'h1006, 1, lat);
    join
    chk("busy_latency", lat, 8);
    chk("busy_mem_addr", last_mem_addr, 15'h1004);
    chk("busy_cache_addr", cache_address, 15'h1006);
    chk("busy_data", cpu_data, 32'hB2);
    chk("busy_misses", miss_count, 4);

    // Back-to-back request in the cycle cpu_ready is high
    do_req(15'h1007, 0, lat);
    chk("b2b_latency", lat, 2);
    chk("b2b_data", cpu_data, 32'hB3);
    chk("b2b_hits", hit_count, 2);

    // Reset while waiting on memory
    cpu_req = 1'b1; cpu_addr = 15'd9;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_mem_read", mem_read, 1);
    chk("mid_misses", miss_count, 5);
    rst = 1'b1; #1;
    chk("mid_rst_mem_read", mem_read, 0);
    chk("mid_rst_busy", cpu_busy, 0);
    chk("mid_rst_hits", hit_count, 0);
    chk("mid_rst_misses", miss_count, 0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    wr0 = wr_cnt;
    mem_word0 = 32'hC0; mem_word1 = 32'hC1; mem_word2 = 32'hC2; mem_word3 = 32'hC3;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("stray_writes", wr_cnt - wr0, 0);
    chk("stray_busy", cpu_busy, 0);

    // Cache contents survive controller reset
    do_req(15'h1006, 0, lat);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_data", cpu_data, 32'hB2);
    chk("post_rst_hits", hit_count, 1);
    chk("post_rst_misses", miss_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
